// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimator sequencer.
package cic_pkg;

    localparam int unsigned OVF_CNT_W = 16;

    typedef enum logic [2:0] {
        OS_NONE = 3'd0,
        OS_2    = 3'd1,
        OS_4    = 3'd2,
        OS_8    = 3'd3,
        OS_16   = 3'd4,
        OS_32   = 3'd5,
        OS_64   = 3'd6,
        OS_INV  = 3'd7
    } os_code_e;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StSettle,
        StRun
    } state_e;

    // Terminal count of the decimation counter, R-1 = 2^code - 1.
    function automatic logic [5:0] os_rm1(input logic [2:0] code);
        logic [6:0] r;
        r = 7'd1 << code;
        return 6'(r - 7'd1);
    endfunction

endpackage

// File: rtl/cic_ovf_mon.sv
// Integrator overflow monitor: toggle baselines, sticky flags, last sign and IRQ.
// Optional saturating event counter when CIC_OVF_CNT_EN is defined.
module cic_ovf_mon
    import cic_pkg::*;
#(
    parameter int unsigned N_STG = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [2*N_STG-1:0]   flag_t_i,
    input  logic                 load_i,
    input  logic                 sample_i,
    input  logic [N_STG-1:0]     clr_i,
    output logic [N_STG-1:0]     sticky_o,
    output logic                 sign_o,
    output logic                 irq_o,
    output logic [OVF_CNT_W-1:0] cnt_o
);

    logic [N_STG-1:0] base_q, base_d;
    logic [N_STG-1:0] sticky_q, sticky_d;
    logic [N_STG-1:0] tog, ev;
    logic             sign_q, sign_d;
    logic             irq_q, irq_d;

    // Ascending loop so the highest firing stage sets the sign last.
    always_comb begin
        tog    = '0;
        ev     = '0;
        sign_d = sign_q;
        for (int i = 0; i < int'(N_STG); i++) begin
            tog[i] = flag_t_i[2*i];
            if (sample_i && (flag_t_i[2*i] != base_q[i])) begin
                ev[i]  = 1'b1;
                sign_d = flag_t_i[2*i+1];
            end
        end
        base_d   = (load_i || sample_i) ? tog : base_q;
        sticky_d = (sticky_q & ~clr_i) | ev;
        irq_d    = |sticky_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_q   <= '0;
            sticky_q <= '0;
            sign_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
            irq_q    <= irq_d;
        end
    end

    assign sticky_o = sticky_q;
    assign sign_o   = sign_q;
    assign irq_o    = irq_q;

`ifdef CIC_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (|ev) begin
            if (|clr_i) begin
                cnt_d = OVF_CNT_W'(1);
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + OVF_CNT_W'(1);
            end
        end else if (|clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: ratio handshake, flush/settle FSM, decimation strobe.
// Overflow event counter is built only when CIC_OVF_CNT_EN is defined.
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int unsigned N_STG = 3,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [2:0]           cfg_os_sel_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic                 cfg_err_o,
    output logic [2:0]           os_sel_o,
    output logic                 dp_clr_o,
    output logic                 dec_stb_o,
    output logic                 out_valid_o,
    input  logic [2*N_STG-1:0]   flag_t_i,
    input  logic [N_STG-1:0]     ovf_clr_i,
    output logic [N_STG-1:0]     ovf_sticky_o,
    output logic                 ovf_sign_o,
    output logic                 ovf_irq_o,
    output logic [OVF_CNT_W-1:0] ovf_cnt_o,
    output logic                 busy_o
);

    localparam int unsigned FlW = $clog2(N_STG + 1);

    state_e           state_q, state_d;
    os_code_e         pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FlW-1:0]   fl_q, fl_d;
    logic [FlW-1:0]   stl_q, stl_d;
    logic             cfg_err_q, cfg_err_d;
    logic [2:0]       os_sel_q, os_sel_d;
    logic             dp_clr_q, dp_clr_d;
    logic             dec_stb_q, dec_stb_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             accept, code_ok, flush_last;
    logic             active_d;

    assign cfg_ready_o = !reset_i && ((state_q == StIdle && enable_i) || state_q == StRun);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign code_ok     = accept && (cfg_os_sel_i != OS_INV);
    assign flush_last  = (state_q == StFlush) && (fl_q == FlW'(N_STG)) && enable_i;

    // dec_stb_q marks the current cycle as the counter's terminal count.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cnt_d     = '0;
        fl_d      = '0;
        stl_d     = stl_q;
        cfg_err_d = accept && (cfg_os_sel_i == OS_INV);
        unique case (state_q)
            StIdle: begin
                if (code_ok) begin
                    pend_d  = os_code_e'(cfg_os_sel_i);
                    state_d = StFlush;
                end
            end
            StFlush: begin
                fl_d = fl_q + FlW'(1);
                if (fl_q == FlW'(N_STG)) begin
                    stl_d   = '0;
                    state_d = (pend_q == OS_NONE) ? StRun : StSettle;
                end
            end
            StSettle: begin
                cnt_d = dec_stb_q ? '0 : cnt_q + CNT_W'(1);
                if (dec_stb_q) begin
                    stl_d = stl_q + FlW'(1);
                    if (stl_q == FlW'(N_STG - 1)) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                cnt_d = dec_stb_q ? '0 : cnt_q + CNT_W'(1);
                if (code_ok) begin
                    pend_d  = os_code_e'(cfg_os_sel_i);
                    state_d = StFlush;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            fl_d    = '0;
        end

        active_d    = (state_d == StSettle) || (state_d == StRun);
        os_sel_d    = active_d ? pend_d : OS_NONE;
        dp_clr_d    = (state_d == StFlush);
        busy_d      = (state_d == StFlush) || (state_d == StSettle);
        dec_stb_d   = active_d && (cnt_d == CNT_W'(os_rm1(pend_d)));
        out_valid_d = (state_d == StRun) && dec_stb_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            pend_q      <= OS_NONE;
            cnt_q       <= '0;
            fl_q        <= '0;
            stl_q       <= '0;
            cfg_err_q   <= 1'b0;
            os_sel_q    <= '0;
            dp_clr_q    <= 1'b0;
            dec_stb_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            fl_q        <= fl_d;
            stl_q       <= stl_d;
            cfg_err_q   <= cfg_err_d;
            os_sel_q    <= os_sel_d;
            dp_clr_q    <= dp_clr_d;
            dec_stb_q   <= dec_stb_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg_err_o   = cfg_err_q;
    assign os_sel_o    = os_sel_q;
    assign dp_clr_o    = dp_clr_q;
    assign dec_stb_o   = dec_stb_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;

    cic_ovf_mon #(
        .N_STG (N_STG)
    ) u_ovf_mon (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .flag_t_i (flag_t_i),
        .load_i   (flush_last),
        .sample_i (out_valid_q),
        .clr_i    (ovf_clr_i),
        .sticky_o (ovf_sticky_o),
        .sign_o   (ovf_sign_o),
        .irq_o    (ovf_irq_o),
        .cnt_o    (ovf_cnt_o)
    );

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl; expectations adapt to CIC_OVF_CNT_EN.
module tb_cic_decim_ctrl;

`ifdef CIC_OVF_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  cfg_os_sel;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_err;
    logic [2:0]  os_sel;
    logic        dp_clr;
    logic        dec_stb;
    logic        out_valid;
    logic [5:0]  flag_t;
    logic [2:0]  ovf_clr;
    logic [2:0]  ovf_sticky;
    logic        ovf_sign;
    logic        ovf_irq;
    logic [15:0] ovf_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cic_decim_ctrl #(
        .N_STG (3),
        .CNT_W (6)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .cfg_os_sel_i (cfg_os_sel),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_err_o    (cfg_err),
        .os_sel_o     (os_sel),
        .dp_clr_o     (dp_clr),
        .dec_stb_o    (dec_stb),
        .out_valid_o  (out_valid),
        .flag_t_i     (flag_t),
        .ovf_clr_i    (ovf_clr),
        .ovf_sticky_o (ovf_sticky),
        .ovf_sign_o   (ovf_sign),
        .ovf_irq_o    (ovf_irq),
        .ovf_cnt_o    (ovf_cnt),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [2:0] code);
        cfg_os_sel = code;
        cfg_valid  = 1'b1;
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Cycle k after the handshake: packed {dp_clr, dec_stb, out_valid, busy, os_sel}.
    task automatic run_cfg(input logic [2:0] code, input int ncyc);
        int   r;
        int   settle_end;
        logic stb;
        logic [6:0] exp;
        r          = 1 << code;
        settle_end = (code == 3'd0) ? 4 : 4 + 3 * r;
        handshake(code);
        for (int k = 1; k <= ncyc; k++) begin
            stb = (k >= 4 + r) && (((k - 4) % r) == 0);
            exp = {1'(k <= 4), stb, 1'(stb && k > settle_end), 1'(k <= settle_end),
                   (k >= 5) ? code : 3'd0};
            check($sformatf("seq c%0d k%0d", code, k),
                  32'({dp_clr, dec_stb, out_valid, busy, os_sel}), 32'(exp));
            if (k < ncyc) tick();
        end
    endtask

    task automatic wait_stb();
        int n;
        n = 0;
        while (dec_stb !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("stb_found", 32'(dec_stb), 32'd1);
    endtask

    task automatic ovf_expect(input string tag, input logic [2:0] st, input logic sg,
                              input int cnt);
        check({tag, " sticky"}, 32'(ovf_sticky), 32'(st));
        check({tag, " irq"}, 32'(ovf_irq), 32'(|st));
        check({tag, " sign"}, 32'(ovf_sign), 32'(sg));
        check({tag, " cnt"}, 32'(ovf_cnt), CntEn ? 32'(cnt) : 32'd0);
    endtask

    initial begin
        logic seen;
        reset      = 1'b1;
        enable     = 1'b1;
        cfg_os_sel = 3'd0;
        cfg_valid  = 1'b0;
        flag_t     = 6'b0;
        ovf_clr    = 3'b0;
        tick();
        tick();
        check("rst cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst outs", 32'({cfg_err, os_sel, dp_clr, dec_stb, out_valid, busy}), 32'd0);
        ovf_expect("rst", 3'b000, 1'b0, 0);

        reset = 1'b0;
        tick();
        check("idle cfg_ready", 32'(cfg_ready), 32'd1);

        // Invalid code in IDLE: error pulse only.
        handshake(3'd7);
        check("err pulse", 32'(cfg_err), 32'd1);
        check("err idle", 32'({busy, dp_clr, os_sel}), 32'd0);
        check("err ready", 32'(cfg_ready), 32'd1);
        tick();
        check("err single", 32'(cfg_err), 32'd0);

        run_cfg(3'd2, 20);
        run_cfg(3'd6, 264);
        run_cfg(3'd1, 14);

        // Overflow monitor in RUN with R=2.
        wait_stb();
        flag_t = 6'b000011;
        tick();
        ovf_expect("ev1", 3'b001, 1'b1, 1);
        wait_stb();
        flag_t = 6'b000000;
        tick();
        ovf_expect("ev2", 3'b001, 1'b0, 2);
        wait_stb();
        flag_t  = 6'b000011;
        ovf_clr = 3'b001;
        tick();
        ovf_clr = 3'b000;
        ovf_expect("ev3 clr", 3'b001, 1'b1, 1);
        ovf_clr = 3'b001;
        tick();
        ovf_clr = 3'b000;
        ovf_expect("clr only", 3'b000, 1'b1, 0);
        wait_stb();
        flag_t = 6'b110000;
        tick();
        ovf_expect("multi", 3'b101, 1'b1, 1);
        wait_stb();
        tick();
        ovf_expect("steady", 3'b101, 1'b1, 1);

        // enable low during SETTLE.
        handshake(3'd2);
        repeat (5) tick();
        check("settle busy", 32'({busy, os_sel}), 32'({1'b1, 3'd2}));
        enable = 1'b0;
        tick();
        check("dis outs", 32'({busy, os_sel, dec_stb, dp_clr, out_valid}), 32'd0);
        check("dis ready", 32'(cfg_ready), 32'd0);
        check("dis keep", 32'(ovf_sticky), 32'b101);
        enable = 1'b1;
        #1;
        check("reen ready", 32'(cfg_ready), 32'd1);
        tick();
        check("reen idle", 32'({busy, dp_clr, os_sel}), 32'd0);

        // Reset mid-FLUSH.
        handshake(3'd1);
        tick();
        check("flush clr", 32'(dp_clr), 32'd1);
        reset = 1'b1;
        tick();
        check("mid rst outs", 32'({cfg_err, os_sel, dp_clr, dec_stb, out_valid, busy}), 32'd0);
        check("mid rst ready", 32'(cfg_ready), 32'd0);
        ovf_expect("mid rst", 3'b000, 1'b0, 0);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | dp_clr | busy;
        end
        check("no flush after rst", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
